// File: rtl/wb_stream_writer_if.sv
// Bundle of the command, AXI-stream, Wishbone and status signals of wb_stream_writer.
//   cmd_*        : command (start byte address, word count) with valid/ready handshake
//   s_axis_*     : incoming stream words; tlast ends a transfer early
//   adr_o..cyc_o : Wishbone master write signals; ack_i/err_i come back from the slave
//   busy, done, status_* : progress and completion report
// The master modport is the writer's view; the slave modport is the environment's view.
interface wb_stream_writer_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = 4,
    parameter int unsigned COUNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [COUNT_WIDTH-1:0]  cmd_len;
    logic                    cmd_valid;
    logic                    cmd_ready;

    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;

    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic                    we_o;
    logic [SELECT_WIDTH-1:0] sel_o;
    logic                    stb_o;
    logic                    cyc_o;
    logic                    ack_i;
    logic                    err_i;

    logic                    busy;
    logic                    done;
    logic [COUNT_WIDTH-1:0]  status_count;
    logic                    status_err;

    modport master (
        input  cmd_addr, cmd_len, cmd_valid,
        output cmd_ready,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
        input  ack_i, err_i,
        output busy, done, status_count, status_err
    );

    modport slave (
        output cmd_addr, cmd_len, cmd_valid,
        input  cmd_ready,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  adr_o, dat_o, we_o, sel_o, stb_o, cyc_o,
        output ack_i, err_i,
        input  busy, done, status_count, status_err
    );
endinterface

// File: rtl/wb_stream_writer.sv
// Wishbone master that writes a sequence of AXI-stream words to consecutive word addresses.
// A command gives a start byte address (low bits forced to word alignment) and a word count;
// the transfer ends when the count is reached, on a tlast beat, or on a bus error. Completion
// is reported with a one-cycle done pulse plus the acknowledged word count and an error flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; drops any bus cycle in flight without a done pulse
//   bus  : wb_stream_writer_if master modport (command, stream, Wishbone, status)
// Each word takes DATA (accept beat) -> WRITE (strobe until ack/err), so stb_o always drops
// for at least one cycle between words.
module wb_stream_writer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = 4,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input logic               clk,
    input logic               rst,
    wb_stream_writer_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(SELECT_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] AddrMask = ~(ADDR_WIDTH'(SELECT_WIDTH - 1));

    typedef enum logic [1:0] {StIdle, StData, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]  len_q, len_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    cmd_fire;
    logic [COUNT_WIDTH-1:0]  count_inc;

    // No accept in the done cycle, so a finished command's status is visible for one cycle.
    assign bus.cmd_ready = (state_q == StIdle) && !done_q && !rst;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign count_inc     = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    addr_d  = bus.cmd_addr & AddrMask;
                    len_d   = bus.cmd_len;
                    count_d = '0;
                    err_d   = 1'b0;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bus.s_axis_tvalid) begin
                    data_d  = bus.s_axis_tdata;
                    last_d  = bus.s_axis_tlast;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // err_i wins over a simultaneous ack_i: the word is not counted.
                if (bus.err_i) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (bus.ack_i) begin
                    count_d = count_inc;
                    addr_d  = addr_q + AddrStep;
                    if ((count_inc == len_q) || last_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.s_axis_tready = (state_q == StData);
    assign bus.stb_o         = (state_q == StWrite);
    assign bus.cyc_o         = (state_q == StWrite);
    assign bus.we_o          = (state_q == StWrite);
    assign bus.sel_o         = (state_q == StWrite) ? '1 : '0;
    assign bus.adr_o         = addr_q;
    assign bus.dat_o         = data_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = done_q;
    // The counter is cleared on accept, so it doubles as the reported count.
    assign bus.status_count  = count_q;
    assign bus.status_err    = err_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer with a wb_ram-like slave (ack one cycle after stb,
// optional extra wait states and error injection on a chosen write attempt).
module tb_wb_stream_writer;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                          .COUNT_WIDTH(CW)) bus ();

    wb_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
                       .COUNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    int cyc_cnt = 0;
    int done_pulses = 0;
    int attempts = 0;
    int err_at = -1;
    int ack_delay = 0;
    int bad_cycle = 0;
    int wait_cnt = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [31:0] mem[logic [31:0]];

    always @(posedge clk) cyc_cnt++;
    always @(negedge clk) if (bus.done) done_pulses++;

    // Slave model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack_i <= 1'b0;
            bus.err_i <= 1'b0;
            wait_cnt = 0;
        end else begin
            bus.ack_i <= 1'b0;
            bus.err_i <= 1'b0;
            if (bus.cyc_o && bus.stb_o && !bus.ack_i && !bus.err_i) begin
                if (wait_cnt >= ack_delay) begin
                    wait_cnt = 0;
                    attempts++;
                    if (!bus.we_o || bus.sel_o !== 4'hF) bad_cycle++;
                    if (attempts == err_at) begin
                        bus.err_i <= 1'b1;
                    end else begin
                        bus.ack_i <= 1'b1;
                        mem[bus.adr_o] = bus.dat_o;
                        log_adr.push_back(bus.adr_o);
                        log_dat.push_back(bus.dat_o);
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
        bit ok = 0;
        bus.cmd_addr = a;
        bus.cmd_len = l;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready got 0, want 1 within 50 cycles");
        end
    endtask

    // Returns at the negedge after the handshake edge; beat_cyc is cyc_cnt in the beat cycle.
    task automatic push_beat(input logic [31:0] d, input bit l, input int gap,
                             output bit ok, output int beat_cyc);
        repeat (gap) @(negedge clk);
        bus.s_axis_tdata = d;
        bus.s_axis_tlast = l;
        bus.s_axis_tvalid = 1'b1;
        ok = 0;
        beat_cyc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.s_axis_tready) begin
                ok = 1;
                beat_cyc = cyc_cnt;
            end
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0;
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(output bit ok, output int done_cyc);
        ok = 0;
        done_cyc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.done) begin
                ok = 1;
                done_cyc = cyc_cnt;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
            $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); end
        checks++; if ({bus.stb_o, bus.cyc_o, bus.we_o, bus.s_axis_tready, bus.busy, bus.done}
                      !== 6'b0) begin errors++;
            $display("FAIL rst_ctrl: got %b want 000000",
                     {bus.stb_o, bus.cyc_o, bus.we_o, bus.s_axis_tready, bus.busy, bus.done}); end
        checks++; if ({bus.adr_o, bus.dat_o, bus.sel_o, bus.status_count, bus.status_err} !== '0)
        begin errors++;
            $display("FAIL rst_data: adr %h dat %h sel %h cnt %0d err %b want all 0",
                     bus.adr_o, bus.dat_o, bus.sel_o, bus.status_count, bus.status_err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL idle_ready: ready %b busy %b want 1 0", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_normal();
        bit ok;
        int bc, first_bc, dc;
        int base = log_adr.size();
        int d0 = done_pulses;
        logic [31:0] exp_a [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
        issue_cmd(32'h100, 16'd4);
        checks++; if (bus.busy !== 1'b1) begin errors++;
            $display("FAIL normal_busy: got %b want 1", bus.busy); end
        first_bc = 0;
        for (int i = 0; i < 4; i++) begin
            push_beat(32'hA0 + i, 1'b0, 0, ok, bc);
            if (i == 0) first_bc = bc;
            checks++; if (!ok) begin errors++;
                $display("FAIL normal_beat%0d: accepted 0 want 1", i); end
        end
        wait_done(ok, dc);
        checks++; if (!ok) begin errors++; $display("FAIL normal_done: got none want pulse"); end
        checks++; if (dc - first_bc != 12) begin errors++;
            $display("FAIL normal_latency: got %0d want 12", dc - first_bc); end
        checks++; if (bus.status_count !== 16'd4 || bus.status_err !== 1'b0) begin errors++;
            $display("FAIL normal_status: cnt %0d err %b want 4 0",
                     bus.status_count, bus.status_err); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++;
            $display("FAIL done_ready: got %b want 0", bus.cmd_ready); end
        @(negedge clk);
        checks++; if (done_pulses - d0 != 1) begin errors++;
            $display("FAIL normal_done_count: got %0d want 1", done_pulses - d0); end
        checks++; if (log_adr.size() - base != 4) begin errors++;
            $display("FAIL normal_writes: got %0d want 4", log_adr.size() - base); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_adr[base+i] !== exp_a[i] || mem[exp_a[i]] !== 32'hA0 + i) begin errors++;
                    $display("FAIL normal_word%0d: adr %h data %h want %h %h", i,
                             log_adr[base+i], mem[exp_a[i]], exp_a[i], 32'hA0 + i); end
            end
        end
        checks++; if (bad_cycle != 0) begin errors++;
            $display("FAIL we_sel: bad cycles %0d want 0", bad_cycle); end
    endtask

    task automatic test_early_tlast();
        bit ok, seen;
        int bc, dc;
        int base = log_adr.size();
        issue_cmd(32'h200, 16'd8);
        for (int i = 0; i < 3; i++) begin
            push_beat(32'hB0 + i, (i == 2), 0, ok, bc);
            checks++; if (!ok) begin errors++;
                $display("FAIL tlast_beat%0d: accepted 0 want 1", i); end
        end
        bus.s_axis_tdata = 32'hB3;
        bus.s_axis_tvalid = 1'b1;
        wait_done(ok, dc);
        checks++; if (!ok || bus.status_count !== 16'd3) begin errors++;
            $display("FAIL tlast_status: done %b cnt %0d want 1 3", ok, bus.status_count); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.s_axis_tready) seen = 1;
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        checks++; if (seen) begin errors++;
            $display("FAIL tlast_beat4: accepted 1 want 0"); end
        checks++; if (log_adr.size() - base != 3 || log_adr[$] !== 32'h208) begin errors++;
            $display("FAIL tlast_writes: got %0d last %h want 3 208",
                     log_adr.size() - base, log_adr[$]); end
    endtask

    task automatic test_bus_error();
        bit ok, found, seen;
        int bc;
        int a0 = attempts;
        err_at = attempts + 2;
        issue_cmd(32'h300, 16'd4);
        push_beat(32'hC0, 1'b0, 0, ok, bc);
        push_beat(32'hC1, 1'b0, 0, ok, bc);
        checks++; if (!ok) begin errors++; $display("FAIL err_beat2: accepted 0 want 1"); end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.err_i) found = 1;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++; if (!found || bus.cyc_o !== 1'b0 || bus.done !== 1'b1) begin errors++;
            $display("FAIL err_cycle_end: err %b cyc %b done %b want 1 0 1",
                     found, bus.cyc_o, bus.done); end
        checks++; if (bus.status_count !== 16'd1 || bus.status_err !== 1'b1) begin errors++;
            $display("FAIL err_status: cnt %0d err %b want 1 1",
                     bus.status_count, bus.status_err); end
        bus.s_axis_tdata = 32'hC2;
        bus.s_axis_tvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.s_axis_tready || bus.cyc_o) seen = 1;
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        err_at = -1;
        checks++; if (seen || attempts - a0 != 2) begin errors++;
            $display("FAIL err_no_third: activity %b attempts %0d want 0 2",
                     seen, attempts - a0); end
    endtask

    task automatic test_zero_len();
        bit seen = 0;
        bus.s_axis_tdata = 32'hD0;
        bus.s_axis_tvalid = 1'b1;
        issue_cmd(32'h400, 16'd0);
        checks++; if (bus.done !== 1'b1 || bus.status_count !== 16'd0 || bus.status_err !== 1'b0)
        begin errors++;
            $display("FAIL zero_done: done %b cnt %0d err %b want 1 0 0",
                     bus.done, bus.status_count, bus.status_err); end
        checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin errors++;
            $display("FAIL zero_flags: busy %b ready %b want 0 0", bus.busy, bus.cmd_ready); end
        for (int i = 0; i < 5; i++) begin
            if (bus.s_axis_tready || bus.cyc_o) seen = 1;
            @(negedge clk);
        end
        bus.s_axis_tvalid = 1'b0;
        checks++; if (seen) begin errors++;
            $display("FAIL zero_quiet: activity 1 want 0"); end
    endtask

    task automatic test_stall_unaligned();
        bit ok;
        int bc, dc, held, unstable;
        int base = log_adr.size();
        logic [31:0] a0, d0;
        ack_delay = 5;
        issue_cmd(32'h103, 16'd2);
        push_beat(32'hE0, 1'b0, 2, ok, bc);
        a0 = bus.adr_o;
        d0 = bus.dat_o;
        held = 0;
        unstable = 0;
        for (int i = 0; i < 20 && bus.stb_o; i++) begin
            if (bus.adr_o !== a0 || bus.dat_o !== d0) unstable++;
            held++;
            @(negedge clk);
        end
        checks++; if (a0 !== 32'h100 || d0 !== 32'hE0) begin errors++;
            $display("FAIL stall_first: adr %h dat %h want 100 e0", a0, d0); end
        checks++; if (unstable != 0 || held != 7) begin errors++;
            $display("FAIL stall_hold: unstable %0d held %0d want 0 7", unstable, held); end
        push_beat(32'hE1, 1'b0, 3, ok, bc);
        wait_done(ok, dc);
        ack_delay = 0;
        checks++; if (!ok || bus.status_count !== 16'd2) begin errors++;
            $display("FAIL stall_status: done %b cnt %0d want 1 2", ok, bus.status_count); end
        checks++; if (log_adr.size() - base != 2 || log_adr[$] !== 32'h104
                      || log_dat[$] !== 32'hE1) begin errors++;
            $display("FAIL stall_writes: n %0d adr %h dat %h want 2 104 e1",
                     log_adr.size() - base, log_adr[$], log_dat[$]); end
    endtask

    task automatic test_reset_wrap();
        bit ok;
        int bc, dc, d0, base;
        ack_delay = 3;
        issue_cmd(32'h500, 16'd4);
        push_beat(32'hF0, 1'b0, 0, ok, bc);
        checks++; if (bus.stb_o !== 1'b1) begin errors++;
            $display("FAIL rw_in_write: stb %b want 1", bus.stb_o); end
        d0 = done_pulses;
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.stb_o, bus.cyc_o, bus.we_o, bus.busy, bus.done, bus.cmd_ready}
                      !== 6'b0 || bus.adr_o !== '0 || bus.dat_o !== '0 || bus.sel_o !== '0
                      || bus.status_count !== '0) begin errors++;
            $display("FAIL async_clear: ctrl %b adr %h dat %h sel %h cnt %0d want all 0",
                     {bus.stb_o, bus.cyc_o, bus.we_o, bus.busy, bus.done, bus.cmd_ready},
                     bus.adr_o, bus.dat_o, bus.sel_o, bus.status_count); end
        ack_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (done_pulses != d0) begin errors++;
            $display("FAIL rst_no_done: got %0d pulses want 0", done_pulses - d0); end
        base = log_adr.size();
        issue_cmd(32'hFFFF_FFFC, 16'd2);
        push_beat(32'h11, 1'b0, 0, ok, bc);
        push_beat(32'h22, 1'b0, 0, ok, bc);
        wait_done(ok, dc);
        checks++; if (!ok || bus.status_count !== 16'd2 || bus.status_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_status: done %b cnt %0d err %b want 1 2 0",
                     ok, bus.status_count, bus.status_err); end
        checks++; if (log_adr.size() - base != 2 || log_adr[base] !== 32'hFFFF_FFFC
                      || log_adr[$] !== 32'h0 || mem[32'h0] !== 32'h22) begin errors++;
            $display("FAIL wrap_addr: n %0d last %h mem0 %h want 2 0 22",
                     log_adr.size() - base, log_adr[$], mem[32'h0]); end
    endtask

    initial begin
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.cmd_valid = 1'b0;
        bus.s_axis_tdata = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast = 1'b0;
        test_reset();
        test_normal();
        test_early_tlast();
        test_bus_error();
        test_zero_len();
        test_stall_unaligned();
        test_reset_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
